// File: rtl/count_reader_tx.sv
// -----------------------------------------------------------------------------
// count_reader_tx
//
// This is the reader side of the event counter. On a request it takes a
// snapshot of the live count. It then sends the snapshot out one beat at a time
// over a valid/ready byte stream. It can also clear the counter, through the
// counter's compare-reset input, on the same edge that the snapshot is taken.
//
// Ports
//   clock         system clock; all logic runs on its rising edge
//   i_reset       synchronous, active-high reset
//   i_count       live counter value (COUNT_WIDTH bits)
//   i_read_req    snapshot request; looked at only while idle
//   i_ready       downstream can accept the current beat
//   o_data        current beat of the snapshot (BYTE_WIDTH bits)
//   o_valid       o_data holds a beat
//   o_comp_reset  clear strobe to the counter (combinational)
//   o_busy        a transfer is in progress (SEND or DONE)
//   o_done        one-cycle pulse after the last beat is accepted
//
// Handshake: a beat is transferred on any rising edge where o_valid and i_ready
// are both high. Once o_valid is raised, it stays high and o_data stays stable
// until that transfer happens. The downstream side may hold i_ready high or low
// freely; it never has to wait for o_valid before raising it.
//
// COUNT_WIDTH must be a non-zero multiple of BYTE_WIDTH.
// -----------------------------------------------------------------------------
module count_reader_tx #(
    parameter int COUNT_WIDTH   = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic [COUNT_WIDTH-1:0] i_count,
    input  logic                   i_read_req,
    input  logic                   i_ready,
    output logic [BYTE_WIDTH-1:0]  o_data,
    output logic                   o_valid,
    output logic                   o_comp_reset,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int NUM_BYTES = COUNT_WIDTH / BYTE_WIDTH;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] snap_q,  snap_d;
    logic [IDX_W-1:0]       idx_q,   idx_d;

    logic [IDX_W-1:0]       sel_idx;
    logic [BYTE_WIDTH-1:0]  sel_byte;

    // Next-state logic. A reset that coincides with a request is handled by
    // the reset branch of the register block, so there is no capture.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (i_read_req) begin
                    snap_d  = i_count;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
        end
    end

    // idx_q counts beats already sent. Translate it into the snapshot byte
    // that should go out next, according to the configured byte order.
    always_comb begin
        sel_idx = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
    end

    always_comb begin
        sel_byte = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (sel_idx == IDX_W'(b)) begin
                sel_byte = snap_q[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Outputs are decoded from the state. o_data reads zero outside SEND, so
    // an old snapshot never appears on the bus while o_valid is low.
    always_comb begin
        o_valid = (state_q == ST_SEND);
        o_busy  = (state_q != ST_IDLE);
        o_done  = (state_q == ST_DONE);
        o_data  = (state_q == ST_SEND) ? sel_byte : '0;
        // The clear strobe is combinational. The counter therefore zeroes on
        // the same edge that this block captures the pre-edge count.
        o_comp_reset = CLEAR_ON_READ && (state_q == ST_IDLE) && i_read_req && !i_reset;
    end

endmodule

// File: tb/tb_count_reader_tx.sv
module tb_count_reader_tx;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_read_req = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_count = '0;

    always #5 clock = ~clock;

    // Three configurations share the same stimulus:
    //   0: MSB first, clear on read
    //   1: LSB first, clear on read
    //   2: MSB first, no clear
    logic [7:0] d_data  [3];
    logic       d_valid [3];
    logic       d_comp  [3];
    logic       d_busy  [3];
    logic       d_done  [3];

    count_reader_tx #(.COUNT_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b1), .CLEAR_ON_READ(1'b1)) u_a (
        .clock(clock), .i_reset(i_reset), .i_count(i_count), .i_read_req(i_read_req),
        .i_ready(i_ready), .o_data(d_data[0]), .o_valid(d_valid[0]),
        .o_comp_reset(d_comp[0]), .o_busy(d_busy[0]), .o_done(d_done[0]));

    count_reader_tx #(.COUNT_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b0), .CLEAR_ON_READ(1'b1)) u_b (
        .clock(clock), .i_reset(i_reset), .i_count(i_count), .i_read_req(i_read_req),
        .i_ready(i_ready), .o_data(d_data[1]), .o_valid(d_valid[1]),
        .o_comp_reset(d_comp[1]), .o_busy(d_busy[1]), .o_done(d_done[1]));

    count_reader_tx #(.COUNT_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1'b1), .CLEAR_ON_READ(1'b0)) u_c (
        .clock(clock), .i_reset(i_reset), .i_count(i_count), .i_read_req(i_read_req),
        .i_ready(i_ready), .o_data(d_data[2]), .o_valid(d_valid[2]),
        .o_comp_reset(d_comp[2]), .o_busy(d_busy[2]), .o_done(d_done[2]));

    function automatic bit msb_of(input int k);
        return (k != 1);
    endfunction

    function automatic bit clr_of(input int k);
        return (k != 2);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: each transfer is a list of bytes in send order,
    // plus a pending "done" pulse once the list has been drained.
    // ------------------------------------------------------------------
    logic [7:0] m_bytes [3][4];
    int         m_left  [3];
    bit         m_done  [3];
    bit         m_fresh [3];

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (i_reset) begin
                m_left[k]  = 0;
                m_done[k]  = 1'b0;
                m_fresh[k] = 1'b1;
            end else if (m_left[k] > 0) begin
                if (i_ready) begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) m_done[k] = 1'b1;
                end
            end else if (m_done[k]) begin
                m_done[k] = 1'b0;
            end else if (i_read_req) begin
                for (int i = 0; i < 4; i++) begin
                    int src;
                    src = msb_of(k) ? (3 - i) : i;
                    m_bytes[k][i] = i_count[src*8 +: 8];
                end
                m_left[k]  = 4;
                m_fresh[k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit chk_en   = 1'b0;

    logic [7:0] got_q [3][$];
    int         done_seen [3];
    int         comp_seen [3];

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, k, $time, got, exp);
        end
    endtask

    // Per-cycle compare, sampled between the drive edge and the next rising edge.
    always @(negedge clock) begin
        #2;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                bit e_valid, e_busy, e_done, e_comp;
                e_valid = (m_left[k] > 0);
                e_busy  = (m_left[k] > 0) || m_done[k];
                e_done  = m_done[k];
                e_comp  = clr_of(k) && !e_busy && i_read_req && !i_reset;
                check("o_valid", k, 32'(d_valid[k]), 32'(e_valid));
                check("o_busy",  k, 32'(d_busy[k]),  32'(e_busy));
                check("o_done",  k, 32'(d_done[k]),  32'(e_done));
                check("o_comp_reset", k, 32'(d_comp[k]), 32'(e_comp));
                if (e_valid)
                    check("o_data", k, 32'(d_data[k]), 32'(m_bytes[k][4 - m_left[k]]));
                else if (m_fresh[k])
                    check("o_data_reset", k, 32'(d_data[k]), 32'h0);
                if (d_valid[k] === 1'b1 && i_ready) got_q[k].push_back(d_data[k]);
                if (d_done[k] === 1'b1) done_seen[k]++;
                if (d_comp[k] === 1'b1) comp_seen[k]++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic cyc(input bit rst, input bit req, input bit rdy, input logic [31:0] cnt);
        @(negedge clock);
        i_reset    = rst;
        i_read_req = req;
        i_ready    = rdy;
        i_count    = cnt;
    endtask

    task automatic clear_log();
        for (int k = 0; k < 3; k++) begin
            got_q[k].delete();
            done_seen[k] = 0;
            comp_seen[k] = 0;
        end
    endtask

    task automatic check_beats(input int k, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp_q[$];
        exp_q = '{b0, b1, b2, b3};
        check("beat_count", k, 32'(got_q[k].size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q[k].size()) check("beat_value", k, 32'(got_q[k][i]), 32'(exp_q[i]));
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit pattern [7];
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        cyc(1, 0, 0, 32'h0);
        cyc(1, 0, 0, 32'h0);
        chk_en = 1'b1;

        // Idle after reset.
        cyc(0, 0, 1, $urandom);
        #3;
        check("reset_valid", 0, 32'(d_valid[0]), 32'h0);
        check("reset_busy",  0, 32'(d_busy[0]),  32'h0);
        check("reset_data",  0, 32'(d_data[0]),  32'h0);
        repeat (4) cyc(0, 0, 1, $urandom);

        // Streaming transfer with i_ready held high.
        clear_log();
        cyc(0, 1, 1, 32'h12345678);
        #3;
        check("comp_in_req_cycle", 0, 32'(d_comp[0]), 32'h1);
        check("comp_disabled",     2, 32'(d_comp[2]), 32'h0);
        repeat (6) cyc(0, 0, 1, 32'h12345678);
        check_beats(0, 8'h12, 8'h34, 8'h56, 8'h78);
        check_beats(1, 8'h78, 8'h56, 8'h34, 8'h12);
        check_beats(2, 8'h12, 8'h34, 8'h56, 8'h78);
        check("done_pulses", 0, 32'(done_seen[0]), 32'd1);
        check("comp_pulses", 0, 32'(comp_seen[0]), 32'd1);

        // Backpressure pattern on i_ready.
        clear_log();
        cyc(0, 1, 0, 32'h12345678);
        for (int i = 0; i < 7; i++) cyc(0, 0, pattern[i], 32'h12345678);
        repeat (3) cyc(0, 0, 1, 32'h12345678);
        check_beats(1, 8'h78, 8'h56, 8'h34, 8'h12);
        check("done_pulses_bp", 1, 32'(done_seen[1]), 32'd1);

        // Count changes and requests repeat during SEND.
        clear_log();
        cyc(0, 1, 1, 32'hFFFFFFFF);
        cyc(0, 1, 1, 32'h0);
        cyc(0, 1, 0, 32'h0);
        cyc(0, 1, 1, 32'h0);
        repeat (6) cyc(0, 0, 1, 32'h0);
        check_beats(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check("comp_once", 0, 32'(comp_seen[0]), 32'd1);
        check("single_done", 0, 32'(done_seen[0]), 32'd1);

        // Reset in the middle of a transfer.
        clear_log();
        cyc(0, 1, 1, 32'hA1B2C3D4);
        cyc(0, 0, 1, 32'hA1B2C3D4);
        cyc(0, 0, 1, 32'hA1B2C3D4);
        cyc(1, 1, 0, 32'hA1B2C3D4);
        cyc(0, 0, 1, 32'hA1B2C3D4);
        #3;
        check("abort_valid", 0, 32'(d_valid[0]), 32'h0);
        check("abort_busy",  0, 32'(d_busy[0]),  32'h0);
        check("abort_beats", 0, 32'(got_q[0].size()), 32'd2);
        check("abort_no_done", 0, 32'(done_seen[0]), 32'd0);
        clear_log();
        cyc(0, 1, 1, 32'h0BADF00D);
        repeat (6) cyc(0, 0, 1, 32'h0BADF00D);
        check_beats(0, 8'h0B, 8'hAD, 8'hF0, 8'h0D);

        // No clear when clear-on-read is disabled.
        clear_log();
        cyc(0, 1, 1, 32'd1000);
        repeat (6) cyc(0, 0, 1, 32'd1000);
        check_beats(2, 8'h00, 8'h00, 8'h03, 8'hE8);
        check("no_comp", 2, 32'(comp_seen[2]), 32'd0);

        // Random traffic checked by the model on every cycle.
        repeat (400) begin
            cyc($urandom_range(0, 99) < 3, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) != 0, $urandom);
        end
        repeat (8) cyc(0, 0, 1, 32'h0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
